filter_verdict: RTL and testbench



---
 rtl/filter_pkg.sv | 41 ++++
 rtl/filter_rule_match.sv | 58 +++++
 rtl/filter_verdict.sv | 167 ++++++++++++++++
 tb/tb_filter_verdict.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared constants, rule layout and FSM encoding for the verdict filter.
package filter_pkg;

  // Stream geometry: beat 0 carries packet bytes 0-31.
  localparam int DATA_W = 256;

  // Ethernet / IPv4 header locations within beat 0.
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam int          OFF_ETHERTYPE  = 12;
  localparam int          OFF_IP_SRC     = 26;
  // Bytes 0..29 must all be present to see the full source address.
  localparam int          RUNT_MIN_BYTES = 30;

  // Verdict encoding pushed into the store stage's result FIFO.
  localparam logic VERDICT_PASS = 1'b1;
  localparam logic VERDICT_DROP = 1'b0;

  // Rule table layout: {valid, action, ip[31:0], mask[31:0]}.
  localparam int IP_W        = 32;
  localparam int RULE_ADDR_W = 4;
  localparam int RULE_W      = 2 + 2 * IP_W;

  typedef struct packed {
    logic            valid;
    logic            action;
    logic [IP_W-1:0] ip;
    logic [IP_W-1:0] mask;
  } rule_t;

  // Packet-framing state: waiting for a start-of-packet or inside a packet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } sop_state_e;

  // Byte k of a beat lives at bits [8k+7:8k].
  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] data, input int k);
    return data[8*k +: 8];
  endfunction

endpackage

// File: rtl/filter_rule_match.sv
// Masked source-address rule table with a write port and a registered hit vector.
module filter_rule_match
  import filter_pkg::*;
#(
  parameter int NUM_RULES = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rule_wr_en,
  input  logic [RULE_ADDR_W-1:0] i_rule_wr_addr,
  input  logic [RULE_W-1:0]      i_rule_wr_data,
  input  logic                   i_sample,
  input  logic [IP_W-1:0]        i_src,
  output logic [NUM_RULES-1:0]   o_hit,
  output logic [NUM_RULES-1:0]   o_action
);

  rule_t                r_rules [NUM_RULES];
  logic [NUM_RULES-1:0] w_hit;
  logic [NUM_RULES-1:0] w_action;
  logic [NUM_RULES-1:0] r_hit;
  logic [NUM_RULES-1:0] r_action;

  // Rule storage: reset only invalidates entries; addresses past the table match no slot.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_RULES; i++) begin
      if (i_reset) begin
        r_rules[i].valid <= 1'b0;
      end else if (i_rule_wr_en && (i_rule_wr_addr == RULE_ADDR_W'(i))) begin
        r_rules[i] <= rule_t'(i_rule_wr_data);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RULES; gi++) begin : g_match
      assign w_hit[gi]    = r_rules[gi].valid &
                            ((i_src & r_rules[gi].mask) == (r_rules[gi].ip & r_rules[gi].mask));
      assign w_action[gi] = r_rules[gi].action;
    end
  endgenerate

  // Snapshot hits and actions together so a later rule write cannot change a pending verdict.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hit    <= '0;
      r_action <= '0;
    end else if (i_sample) begin
      r_hit    <= w_hit;
      r_action <= w_action;
    end
  end

  assign o_hit    = r_hit;
  assign o_action = r_action;

endmodule

// File: rtl/filter_verdict.sv
// In-line AXI-Stream filter: passes beats through, parses each packet's first beat
// and pushes one forward/drop verdict per packet into the store stage's result FIFO.
module filter_verdict
  import filter_pkg::*;
#(
  parameter int   C_S_AXIS_DATA_WIDTH  = 256,
  parameter int   C_S_AXIS_TUSER_WIDTH = 128,
  parameter int   NUM_RULES            = 8,
  parameter logic DEFAULT_ACTION       = VERDICT_PASS,
  parameter logic NON_IP_ACTION        = VERDICT_PASS,
  parameter logic RUNT_ACTION          = VERDICT_DROP
) (
  input  logic                              axi_aclk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              result_wr_en,
  output logic                              result_din,
  input  logic                              result_nearly_full,
  input  logic                              rule_wr_en,
  input  logic [RULE_ADDR_W-1:0]            rule_wr_addr,
  input  logic [RULE_W-1:0]                 rule_wr_data,
  output logic [31:0]                       pass_count,
  output logic [31:0]                       drop_count
);

  sop_state_e           r_state;
  sop_state_e           w_state_next;
  logic                 w_allow;
  logic                 w_accept;
  logic                 w_sop;
  logic [15:0]          w_ethertype;
  logic [IP_W-1:0]      w_src;
  logic                 r_v1;
  logic                 r_v2;
  logic                 r_is_ip;
  logic                 r_runt;
  logic [IP_W-1:0]      r_src;
  logic [NUM_RULES-1:0] w_hit;
  logic [NUM_RULES-1:0] w_action;
  logic                 w_verdict;
  logic [31:0]          r_pass_count;
  logic [31:0]          r_drop_count;

  // Header fields straight off the incoming beat; only meaningful on the SOP beat.
  assign w_ethertype = {get_byte(s_axis_tdata, OFF_ETHERTYPE),
                        get_byte(s_axis_tdata, OFF_ETHERTYPE + 1)};
  assign w_src       = {get_byte(s_axis_tdata, OFF_IP_SRC),
                        get_byte(s_axis_tdata, OFF_IP_SRC + 1),
                        get_byte(s_axis_tdata, OFF_IP_SRC + 2),
                        get_byte(s_axis_tdata, OFF_IP_SRC + 3)};

  assign w_accept = s_axis_tvalid & s_axis_tready;
  assign w_sop    = w_accept & (r_state == ST_IDLE);

  // Framing state register.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Framing next state: single-beat packets never leave IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !s_axis_tlast) w_state_next = ST_BODY;
      ST_BODY: if (w_accept &&  s_axis_tlast) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Gate output: mid-packet beats always flow; a new packet waits until no verdict is in flight.
  always_comb begin
    w_allow = (r_state == ST_BODY) | (!r_v1 & !r_v2 & !result_nearly_full);
  end

  assign s_axis_tready = m_axis_tready & w_allow;
  assign m_axis_tvalid = s_axis_tvalid & w_allow;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tstrb  = s_axis_tstrb;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;

  // Stage 1: capture header facts on the SOP. These registers stay stable until the
  // verdict is written, because no further SOP is accepted while v1/v2 are set.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_v1    <= 1'b0;
      r_is_ip <= 1'b0;
      r_runt  <= 1'b0;
      r_src   <= '0;
    end else begin
      r_v1 <= w_sop;
      if (w_sop) begin
        r_is_ip <= (w_ethertype == ETHERTYPE_IPV4);
        r_runt  <= ~&s_axis_tstrb[RUNT_MIN_BYTES-1:0];
        r_src   <= w_src;
      end
    end
  end

  filter_rule_match #(
    .NUM_RULES (NUM_RULES)
  ) u_rule_match (
    .i_clk          (axi_aclk),
    .i_reset        (reset),
    .i_rule_wr_en   (rule_wr_en),
    .i_rule_wr_addr (rule_wr_addr),
    .i_rule_wr_data (rule_wr_data),
    .i_sample       (r_v1),
    .i_src          (r_src),
    .o_hit          (w_hit),
    .o_action       (w_action)
  );

  // Stage 2: verdict pending until the result FIFO has room.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_v2 <= 1'b0;
    end else if (r_v1) begin
      r_v2 <= 1'b1;
    end else if (result_wr_en) begin
      r_v2 <= 1'b0;
    end
  end

  // Verdict priority: runt, then non-IPv4, then lowest-index hit, then default.
  always_comb begin
    w_verdict = DEFAULT_ACTION;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_verdict = w_action[i];
    end
    if (!r_is_ip) w_verdict = NON_IP_ACTION;
    if (r_runt)   w_verdict = RUNT_ACTION;
  end

  assign result_wr_en = r_v2 & !result_nearly_full;
  assign result_din   = w_verdict;

  // Wrapping verdict statistics.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      r_pass_count <= '0;
      r_drop_count <= '0;
    end else if (result_wr_en) begin
      if (result_din == VERDICT_PASS) r_pass_count <= r_pass_count + 32'd1;
      else                            r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign pass_count = r_pass_count;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_filter_verdict.sv
// Self-checking bench for filter_verdict: directed table, corner sequences, random packets.
module tb_filter_verdict;

  logic         axi_aclk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         result_wr_en;
  logic         result_din;
  logic         result_nearly_full = 1'b0;
  logic         rule_wr_en = 1'b0;
  logic [3:0]   rule_wr_addr = '0;
  logic [65:0]  rule_wr_data = '0;
  logic [31:0]  pass_count;
  logic [31:0]  drop_count;

  always #5 axi_aclk = ~axi_aclk;

  filter_verdict dut (
    .axi_aclk           (axi_aclk),
    .reset              (reset),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tstrb       (s_axis_tstrb),
    .s_axis_tuser       (s_axis_tuser),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tstrb       (m_axis_tstrb),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .result_wr_en       (result_wr_en),
    .result_din         (result_din),
    .result_nearly_full (result_nearly_full),
    .rule_wr_en         (rule_wr_en),
    .rule_wr_addr       (rule_wr_addr),
    .rule_wr_data       (rule_wr_data),
    .pass_count         (pass_count),
    .drop_count         (drop_count)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;

  // Reference model state: rule table and verdict counts.
  logic        m_valid [8];
  logic        m_action [8];
  logic [31:0] m_ip [8];
  logic [31:0] m_mask [8];
  int unsigned m_pass = 0;
  int unsigned m_drop = 0;

  // Observed verdict writes (value and cycle).
  logic wr_din_q [$];
  int   wr_cyc_q [$];

  always @(posedge axi_aclk) cyc <= cyc + 1;

  always @(negedge axi_aclk) begin
    if (result_wr_en === 1'b1) begin
      wr_din_q.push_back(result_din);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Spec-level verdict: runt first, then non-IPv4, then first matching rule, else default.
  function automatic logic model_verdict(input logic [15:0] et, input logic [31:0] src,
                                         input logic [31:0] strb);
    if (strb[29:0] != 30'h3FFF_FFFF) return 1'b0;
    if (et != 16'h0800) return 1'b1;
    for (int i = 0; i < 8; i++)
      if (m_valid[i] && (((src ^ m_ip[i]) & m_mask[i]) == 32'd0)) return m_action[i];
    return 1'b1;
  endfunction

  function automatic logic [255:0] make_beat0(input logic [15:0] et, input logic [31:0] src);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    d[8*12 +: 8] = et[15:8];
    d[8*13 +: 8] = et[7:0];
    d[8*26 +: 8] = src[31:24];
    d[8*27 +: 8] = src[23:16];
    d[8*28 +: 8] = src[15:8];
    d[8*29 +: 8] = src[7:0];
    return d;
  endfunction

  task automatic set_rule(input logic [3:0] a, input logic v, input logic act,
                          input logic [31:0] ip, input logic [31:0] mask);
    rule_wr_en   = 1'b1;
    rule_wr_addr = a;
    rule_wr_data = {v, act, ip, mask};
    @(posedge axi_aclk); #1;
    rule_wr_en = 1'b0;
    if (a < 4'd8) begin
      m_valid[a] = v; m_action[a] = act; m_ip[a] = ip; m_mask[a] = mask;
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_pass = 0;
    m_drop = 0;
  endfunction

  // Present one beat and hold it until accepted (bounded); checks pass-through on accept.
  task automatic drive_beat(input logic [255:0] d, input logic [31:0] strb, input logic last,
                            output int acc_cyc, output bit ok);
    int g = 0;
    s_axis_tdata  = d;
    s_axis_tstrb  = strb;
    s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    while (!ok && g < 200) begin
      @(negedge axi_aclk);
      if (s_axis_tready) ok = 1'b1;
      g++;
    end
    acc_cyc = cyc;
    check("beat_accept", 32'(ok), 1);
    if (ok)
      check("passthru", 32'(m_axis_tvalid && m_axis_tdata == d && m_axis_tstrb == strb &&
                            m_axis_tlast == last && m_axis_tuser == s_axis_tuser), 1);
    @(posedge axi_aclk); #1;
  endtask

  task automatic wait_verdict(input logic exp, input string name, output int wcyc);
    int   g = 0;
    logic v;
    while (wr_din_q.size() == 0 && g < 50) begin
      @(negedge axi_aclk);
      g++;
    end
    check({name, "_present"}, 32'(wr_din_q.size() != 0), 1);
    wcyc = -1;
    if (wr_din_q.size() != 0) begin
      v    = wr_din_q.pop_front();
      wcyc = wr_cyc_q.pop_front();
      check({name, "_verdict"}, 32'(v), 32'(exp));
    end
    if (exp) m_pass++; else m_drop++;
  endtask

  task automatic check_counters(input string name);
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    check({name, "_pass_count"}, pass_count, m_pass);
    check({name, "_drop_count"}, drop_count, m_drop);
    @(posedge axi_aclk); #1;
  endtask

  task automatic run_pkt(input logic [15:0] et, input logic [31:0] src, input int nbeats,
                         input logic [31:0] strb0, input logic exp, input string name);
    int sop, tmp, wc;
    bit ok;
    drive_beat(make_beat0(et, src), strb0, nbeats == 1, sop, ok);
    for (int b = 1; b < nbeats; b++)
      drive_beat(make_beat0(16'($urandom), $urandom), 32'hFFFF_FFFF, b == nbeats - 1, tmp, ok);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    wait_verdict(exp, name, wc);
    check({name, "_latency"}, wc - sop, 2);
    check_counters(name);
    $display("pkt %s et=%h src=%h beats=%0d strb=%h verdict_exp=%0d",
             name, et, src, nbeats, strb0, exp);
  endtask

  typedef struct {
    bit          do_rule;
    logic [3:0]  raddr;
    logic        rvalid;
    logic        ract;
    logic [31:0] rip;
    logic [31:0] rmask;
    logic [15:0] et;
    logic [31:0] src;
    int          nbeats;
    logic [31:0] strb;
    logic        exp;
    string       name;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int  sop, sop2, rel, wc, tmp;
    int  acc [3];
    bit  ok, hold_ok;
    logic [15:0] r_et;
    logic [31:0] r_src, r_strb, r_ip;

    model_reset();

    // Reset state.
    repeat (3) @(posedge axi_aclk);
    #1 reset = 1'b0;
    @(negedge axi_aclk);
    check("rst_tready", 32'(s_axis_tready), 1);
    check("rst_wr_en", 32'(result_wr_en), 0);
    check("rst_pass_count", pass_count, 0);
    check("rst_drop_count", drop_count, 0);
    @(posedge axi_aclk); #1;

    // Directed vectors: optional rule write, then one packet.
    vecs[0]  = '{1, 4'd0, 1, 0, 32'h0A00_0005, 32'hFFFF_FFFF, 16'h0800, 32'h0A00_0005, 2, 32'hFFFF_FFFF, 0, "rule0_exact"};
    vecs[1]  = '{1, 4'd0, 0, 0, 32'h0A00_0005, 32'hFFFF_FFFF, 16'h0800, 32'hC0A8_0101, 1, 32'hFFFF_FFFF, 1, "default_pass"};
    vecs[2]  = '{1, 4'd1, 1, 1, 32'h0A00_0000, 32'hFF00_0000, 16'h0800, 32'h0A01_0203, 1, 32'hFFFF_FFFF, 1, "rule1_only"};
    vecs[3]  = '{1, 4'd3, 1, 0, 32'h0A01_0000, 32'hFFFF_0000, 16'h0800, 32'h0A01_0203, 3, 32'hFFFF_FFFF, 1, "lowest_wins"};
    vecs[4]  = '{1, 4'd1, 0, 1, 32'h0A00_0000, 32'hFF00_0000, 16'h0800, 32'h0A01_0203, 1, 32'hFFFF_FFFF, 0, "rule3_after_clear"};
    vecs[5]  = '{0, 4'd0, 0, 0, 32'h0,         32'h0,         16'h0806, 32'h0A01_0203, 2, 32'hFFFF_FFFF, 1, "non_ip"};
    vecs[6]  = '{0, 4'd0, 0, 0, 32'h0,         32'h0,         16'h0800, 32'hC0A8_0101, 1, 32'h0000_FFFF, 0, "runt"};
    vecs[7]  = '{1, 4'd9, 1, 0, 32'h0,         32'h0,         16'h0800, 32'hC0A8_0101, 1, 32'hFFFF_FFFF, 1, "addr_out_of_range"};
    vecs[8]  = '{0, 4'd0, 0, 0, 32'h0,         32'h0,         16'h0800, 32'hC0A8_0101, 1, 32'h3FFF_FFFF, 1, "strb_30_bytes"};
    vecs[9]  = '{0, 4'd0, 0, 0, 32'h0,         32'h0,         16'h0800, 32'hC0A8_0101, 1, 32'h1FFF_FFFF, 0, "strb_29_bytes"};
    vecs[10] = '{0, 4'd0, 0, 0, 32'h0,         32'h0,         16'h0806, 32'hC0A8_0101, 1, 32'h0000_00FF, 0, "runt_non_ip"};

    foreach (vecs[i]) begin
      if (vecs[i].do_rule)
        set_rule(vecs[i].raddr, vecs[i].rvalid, vecs[i].ract, vecs[i].rip, vecs[i].rmask);
      run_pkt(vecs[i].et, vecs[i].src, vecs[i].nbeats, vecs[i].strb, vecs[i].exp, vecs[i].name);
    end

    // Back-pressure from the result FIFO holds the verdict and the next SOP.
    drive_beat(make_beat0(16'h0806, 32'h0), 32'hFFFF_FFFF, 1'b1, sop, ok);
    result_nearly_full = 1'b1;
    s_axis_tdata  = make_beat0(16'h0800, 32'hC0A8_0101);
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    hold_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge axi_aclk);
      if (result_wr_en || s_axis_tready) hold_ok = 1'b0;
      @(posedge axi_aclk); #1;
    end
    check("nf_hold_quiet", 32'(hold_ok), 1);
    check("nf_hold_no_write", wr_din_q.size(), 0);
    result_nearly_full = 1'b0;
    @(negedge axi_aclk);
    rel = cyc;
    check("nf_release_wr_en", 32'(result_wr_en), 1);
    check("nf_release_tready", 32'(s_axis_tready), 0);
    @(posedge axi_aclk); #1;
    @(negedge axi_aclk);
    sop2 = cyc;
    check("nf_next_sop_tready", 32'(s_axis_tready), 1);
    @(posedge axi_aclk); #1;
    s_axis_tvalid = 1'b0;
    wait_verdict(1'b1, "nf_first", wc);
    check("nf_first_cycle", wc, rel);
    wait_verdict(1'b1, "nf_second", wc);
    check("nf_second_latency", wc - sop2, 2);
    check_counters("nf");
    $display("seq nearly_full hold=10 release_cycle=%0d next_sop=%0d", rel, sop2);

    // Back-to-back single-beat packets are spaced three cycles apart.
    for (int k = 0; k < 3; k++)
      drive_beat(make_beat0(16'h0806, $urandom), 32'hFFFF_FFFF, 1'b1, acc[k], ok);
    s_axis_tvalid = 1'b0;
    check("b2b_gap01", acc[1] - acc[0], 3);
    check("b2b_gap12", acc[2] - acc[1], 3);
    for (int k = 0; k < 3; k++) wait_verdict(1'b1, "b2b", wc);
    check_counters("b2b");
    $display("seq back_to_back sops=%0d,%0d,%0d", acc[0], acc[1], acc[2]);

    // Reset in the middle of a packet.
    drive_beat(make_beat0(16'h0800, 32'hC0A8_0101), 32'hFFFF_FFFF, 1'b0, sop, ok);
    s_axis_tvalid = 1'b0;
    reset = 1'b1;
    @(posedge axi_aclk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge axi_aclk);
    check("mid_rst_tready", 32'(s_axis_tready), 1);
    check("mid_rst_wr_en", 32'(result_wr_en), 0);
    check("mid_rst_pass_count", pass_count, 0);
    check("mid_rst_drop_count", drop_count, 0);
    m_axis_tready = 1'b0;
    #1 check("mid_rst_tready_mready0", 32'(s_axis_tready), 0);
    m_axis_tready = 1'b1;
    result_nearly_full = 1'b1;
    #1 check("mid_rst_tready_nf1", 32'(s_axis_tready), 0);
    result_nearly_full = 1'b0;
    repeat (4) @(negedge axi_aclk);
    check("mid_rst_no_write", wr_din_q.size(), 0);
    @(posedge axi_aclk); #1;
    $display("seq reset_mid_packet sop=%0d", sop);
    // Rules were cleared by reset, so an IPv4 packet takes the default verdict.
    run_pkt(16'h0800, 32'h0A00_0005, 1, 32'hFFFF_FFFF, 1'b1, "post_reset");

    // Random packets against the reference model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        r_ip = {8'h0A, 8'($urandom_range(0, 3)), 16'($urandom)};
        set_rule(4'($urandom_range(0, 9)), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 r_ip, 32'hFFFF_FFFF << $urandom_range(0, 32));
      end
      r_et   = ($urandom_range(0, 4) != 0) ? 16'h0800 : 16'($urandom);
      r_src  = ($urandom_range(0, 4) != 0) ? {8'h0A, 8'($urandom_range(0, 3)), 16'($urandom)}
                                           : $urandom;
      r_strb = ($urandom_range(0, 6) != 0) ? 32'hFFFF_FFFF : $urandom;
      run_pkt(r_et, r_src, $urandom_range(1, 3), r_strb,
              model_verdict(r_et, r_src, r_strb), "random");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
